// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared architectural constants for the register file and its scoreboard.
//   REGISTER_FILE_NUM           number of architectural registers
//   RISC_V_DATA_WIDTH           register width in bits
//   REGISTER_FILE_ADDRESS_WIDTH width of a register-number field
//   reg_num_t                   register-number type
//   reg_live()                  true for a register that can hold state
//                               (nonzero and inside the register file)
// -----------------------------------------------------------------------------
package common_pkg;

    localparam int REGISTER_FILE_NUM           = 32;
    localparam int RISC_V_DATA_WIDTH           = 64;
    localparam int REGISTER_FILE_ADDRESS_WIDTH = $clog2(REGISTER_FILE_NUM);

    typedef logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_t;

    // Register 0 is hardwired to zero and out-of-range numbers address
    // nothing, so neither may be written, marked busy, or read back nonzero.
    function automatic logic reg_live(input int idx, input int num_regs);
        return (idx != 0) && (idx < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-producer bit per architectural register.
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears every busy bit
//   i_issue_en   set busy[i_issue_reg] on the next edge
//   i_issue_reg  destination register being issued
//   i_wr_en      per-port write enable, a write clears busy[i_wr_reg]
//   i_wr_reg     per-port write register number
//   o_busy       registered busy vector (bit 0 is always 0)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import common_pkg::*;
#(
    parameter  int NUM_REGS = REGISTER_FILE_NUM,
    parameter  int NUM_WR   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_issue_en,
    input  logic [AW-1:0]             i_issue_reg,
    input  logic [NUM_WR-1:0]         i_wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] i_wr_reg,
    output logic [NUM_REGS-1:0]       o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    // Clears are applied first and the issue last, so a same-cycle
    // write and issue of one register leaves it busy: the issue belongs
    // to a newer producer than the value being written back.
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (i_wr_en[w] && reg_live(int'(i_wr_reg[w]), NUM_REGS)) begin
                w_busy_next[i_wr_reg[w]] = 1'b0;
            end
        end
        if (i_issue_en && reg_live(int'(i_issue_reg), NUM_REGS)) begin
            w_busy_next[i_issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-ported flip-flop register file with a per-register busy scoreboard.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (registers and busy bits)
//   rd_reg     NUM_RD read register numbers
//   rd_data    NUM_RD combinational read data
//   rd_busy    NUM_RD busy bits of the addressed registers
//   wr_en      NUM_WR write enables
//   wr_reg     NUM_WR write register numbers
//   wr_data    NUM_WR write data (highest port wins on a collision)
//   issue_en   mark issue_reg as having a producer in flight
//   issue_reg  destination register being issued
//   debug      bits [15:0] of register DEBUG_REG
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the resulting busy state) to the read ports and debug output.
// -----------------------------------------------------------------------------
module register_file_mp
    import common_pkg::*;
#(
    parameter  int NUM_REGS   = REGISTER_FILE_NUM,
    parameter  int DATA_WIDTH = RISC_V_DATA_WIDTH,
    parameter  int NUM_RD     = 2,
    parameter  int NUM_WR     = 1,
    parameter  int DEBUG_REG  = 31,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD-1:0][AW-1:0]         rd_reg,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]                 rd_busy,
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]         wr_reg,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic                              issue_en,
    input  logic [AW-1:0]                     issue_reg,
    output logic [15:0]                       debug
);

    localparam logic [AW-1:0] DBG_IDX = AW'(DEBUG_REG);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_busy;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_issue_en  (issue_en),
        .i_issue_reg (issue_reg),
        .i_wr_en     (wr_en),
        .i_wr_reg    (wr_reg),
        .o_busy      (w_busy)
    );

    // Ports are visited in ascending order, so the last nonblocking
    // assignment (highest port) wins when several target one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && reg_live(int'(wr_reg[w]), NUM_REGS)) begin
                    r_regs[wr_reg[w]] <= wr_data[w];
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] lookup_data(input logic [AW-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (reg_live(int'(idx), NUM_REGS)) begin
            v = r_regs[idx];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed under reset so outputs stay at 0.
            for (int w = 0; w < NUM_WR; w++) begin
                if (!rst && wr_en[w] && (wr_reg[w] == idx)) begin
                    v = wr_data[w];
                end
            end
`endif
        end
        return v;
    endfunction

    function automatic logic lookup_busy(input logic [AW-1:0] idx);
        logic b;
        b = 1'b0;
        if (reg_live(int'(idx), NUM_REGS)) begin
            b = w_busy[idx];
`ifdef REGFILE_BYPASS_EN
            // A forwarded write retires the producer, unless a newer
            // producer is issued to the same register in this cycle.
            for (int w = 0; w < NUM_WR; w++) begin
                if (!rst && wr_en[w] && (wr_reg[w] == idx)) begin
                    b = issue_en && (issue_reg == idx);
                end
            end
`endif
        end
        return b;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = lookup_data(rd_reg[p]);
            rd_busy[p] = lookup_busy(rd_reg[p]);
        end
        debug = 16'(lookup_data(DBG_IDX));
    end

endmodule
